// File: rtl/sim_top_pkg.sv
// ============================================================================
// sim_top_pkg : shared defaults, link state encoding and helpers (rev 1.0)
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package sim_top_pkg;

  localparam int DEF_PCIE_LANES    = 16;
  localparam int DEF_QSFP_LANES    = 4;
  localparam int DEF_MON_WINDOW    = 256;
  localparam int DEF_MON_MIN_EDGES = 16;
  localparam int T_TRAIN_FAST      = 16;
  localparam int T_TRAIN_SLOW      = 1024;

  typedef enum logic [1:0] {
    LINK_DOWN  = 2'd0,
    LINK_TRAIN = 2'd1,
    LINK_UP    = 2'd2
  } link_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reference_switch_lite_sim_top_if.sv
// ============================================================================
// reference_switch_lite_sim_top_if : reference clocks and serial lane pins (rev 1.0)
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface reference_switch_lite_sim_top_if #(
  parameter int PCIE_LANES = 16,
  parameter int QSFP_LANES = 4
);
  logic                  pci_clk_p;
  logic                  pci_clk_n;
  logic                  qsfp_refclk_p;
  logic                  qsfp_refclk_n;
  logic [PCIE_LANES-1:0] pcie_rxp;
  logic [PCIE_LANES-1:0] pcie_rxn;
  logic [PCIE_LANES-1:0] pcie_txp;
  logic [PCIE_LANES-1:0] pcie_txn;
  logic [QSFP_LANES-1:0] qsfp0_rxp;
  logic [QSFP_LANES-1:0] qsfp0_rxn;
  logic [QSFP_LANES-1:0] qsfp0_txp;
  logic [QSFP_LANES-1:0] qsfp0_txn;

  modport slave (
    input  pci_clk_p, pci_clk_n, qsfp_refclk_p, qsfp_refclk_n,
    input  pcie_rxp, pcie_rxn, qsfp0_rxp, qsfp0_rxn,
    output pcie_txp, pcie_txn, qsfp0_txp, qsfp0_txn
  );

  modport master (
    output pci_clk_p, pci_clk_n, qsfp_refclk_p, qsfp_refclk_n,
    output pcie_rxp, pcie_rxn, qsfp0_rxp, qsfp0_rxn,
    input  pcie_txp, pcie_txn, qsfp0_txp, qsfp0_txn
  );
endinterface

`default_nettype wire

// File: rtl/reference_switch_lite_sim_top_clk_alive_mon.sv
// ============================================================================
// clk_alive_mon : counts reference-clock edges per core window (rev 1.0)
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module clk_alive_mon
  import sim_top_pkg::*;
#(
  parameter int MON_WINDOW    = DEF_MON_WINDOW,
  parameter int MON_MIN_EDGES = DEF_MON_MIN_EDGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ref_clk,
  output logic alive
);

  localparam int c_win_w = (MON_WINDOW > 1) ? $clog2(MON_WINDOW) : 1;
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(MON_WINDOW - 1);

  logic [2:0]         r_sync;
  logic [c_win_w-1:0] r_win_cnt;
  logic [7:0]         r_edge_cnt;
  logic               w_edge;
  logic               w_win_end;
  logic [7:0]         w_cnt_next;

  assign w_edge     = r_sync[1] & ~r_sync[2];
  assign w_win_end  = (r_win_cnt == c_win_last);
  // The verdict includes an edge seen in the window's last cycle.
  assign w_cnt_next = sat_inc(r_edge_cnt, w_edge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
      alive      <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], ref_clk};
      if (w_win_end) begin
        r_win_cnt  <= '0;
        r_edge_cnt <= '0;
        alive      <= (int'(w_cnt_next) >= MON_MIN_EDGES);
      end else begin
        r_win_cnt  <= r_win_cnt + 1'b1;
        r_edge_cnt <= w_cnt_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reference_switch_lite_sim_top_lane_link.sv
// ============================================================================
// lane_link : link training FSM plus two-stage registered lane loopback (rev 1.0)
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lane_link
  import sim_top_pkg::*;
#(
  parameter int LANES   = DEF_PCIE_LANES,
  parameter int T_TRAIN = T_TRAIN_FAST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rst_core_n,
  input  logic             alive,
  input  logic [LANES-1:0] rxp,
  output logic [LANES-1:0] txp,
  output logic [LANES-1:0] txn,
  output logic             link_up
);

  localparam int c_cnt_w = (T_TRAIN > 1) ? $clog2(T_TRAIN) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(T_TRAIN - 1);

  link_state_t        r_state;
  logic [c_cnt_w-1:0] r_train_cnt;
  logic [LANES-1:0]   r_stage1;
  logic [LANES-1:0]   r_stage2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LINK_DOWN;
      r_train_cnt <= '0;
      r_stage1    <= '0;
      r_stage2    <= '0;
      link_up     <= 1'b0;
    end else begin
      r_stage1 <= rxp;
      r_stage2 <= r_stage1;
      // Losing the reference clock overrides any pending training completion.
      if (!alive || !rst_core_n) begin
        r_state     <= LINK_DOWN;
        r_train_cnt <= '0;
        link_up     <= 1'b0;
      end else begin
        case (r_state)
          LINK_DOWN: begin
            r_state     <= LINK_TRAIN;
            r_train_cnt <= '0;
            link_up     <= 1'b0;
          end
          LINK_TRAIN: begin
            if (r_train_cnt == c_cnt_last) begin
              r_state <= LINK_UP;
              link_up <= 1'b1;
            end else begin
              r_train_cnt <= r_train_cnt + 1'b1;
            end
          end
          LINK_UP: begin
            link_up <= 1'b1;
          end
          default: begin
            r_state <= LINK_DOWN;
            link_up <= 1'b0;
          end
        endcase
      end
    end
  end

  assign txp = link_up ? r_stage2  : '0;
  assign txn = link_up ? ~r_stage2 : '1;

endmodule

`default_nettype wire

// File: rtl/reference_switch_lite_sim_top.sv
// ============================================================================
// reference_switch_lite_sim_top : pin-level shell with behavioural lane loopback (rev 1.0)
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module reference_switch_lite_sim_top
  import sim_top_pkg::*;
#(
  parameter string       PL_SIM_FAST_LINK_TRAINING         = "TRUE",
  parameter int          C_DATA_WIDTH                      = 512,
  parameter int          KEEP_WIDTH                        = C_DATA_WIDTH / 32,
  parameter int          USER_CLK2_FREQ                    = 4,
  parameter int          REF_CLK_FREQ                      = 0,
  parameter string       AXISTEN_IF_RQ_ALIGNMENT_MODE      = "FALSE",
  parameter string       AXISTEN_IF_CC_ALIGNMENT_MODE      = "FALSE",
  parameter string       AXISTEN_IF_CQ_ALIGNMENT_MODE      = "FALSE",
  parameter string       AXISTEN_IF_RC_ALIGNMENT_MODE      = "FALSE",
  parameter int          AXISTEN_IF_ENABLE_CLIENT_TAG      = 0,
  parameter int          AXISTEN_IF_RQ_PARITY_CHECK        = 0,
  parameter int          AXISTEN_IF_CC_PARITY_CHECK        = 0,
  parameter int          AXISTEN_IF_MC_RX_STRADDLE         = 0,
  parameter int          AXISTEN_IF_ENABLE_RX_MSG_INTFC    = 0,
  parameter logic [17:0] AXISTEN_IF_ENABLE_MSG_ROUTE       = 18'h2FFFF,
  parameter int          PCIE_LANES                        = DEF_PCIE_LANES,
  parameter int          QSFP_LANES                        = DEF_QSFP_LANES,
  parameter int          MON_WINDOW                        = DEF_MON_WINDOW,
  parameter int          MON_MIN_EDGES                     = DEF_MON_MIN_EDGES
) (
  input  logic fpga_sysclk_p,
  input  logic fpga_sysclk_n,
  input  logic sys_reset_n,
  reference_switch_lite_sim_top_if.slave pins
);

  localparam int c_t_train = (PL_SIM_FAST_LINK_TRAINING == "TRUE") ? T_TRAIN_FAST : T_TRAIN_SLOW;

  // Integration-only parameters are carried for the project bench and have no logic.
  localparam int c_unused_cfg = C_DATA_WIDTH + KEEP_WIDTH + USER_CLK2_FREQ + REF_CLK_FREQ
    + ((AXISTEN_IF_RQ_ALIGNMENT_MODE == "TRUE") ? 1 : 0)
    + ((AXISTEN_IF_CC_ALIGNMENT_MODE == "TRUE") ? 1 : 0)
    + ((AXISTEN_IF_CQ_ALIGNMENT_MODE == "TRUE") ? 1 : 0)
    + ((AXISTEN_IF_RC_ALIGNMENT_MODE == "TRUE") ? 1 : 0)
    + AXISTEN_IF_ENABLE_CLIENT_TAG + AXISTEN_IF_RQ_PARITY_CHECK + AXISTEN_IF_CC_PARITY_CHECK
    + AXISTEN_IF_MC_RX_STRADDLE + AXISTEN_IF_ENABLE_RX_MSG_INTFC
    + int'(AXISTEN_IF_ENABLE_MSG_ROUTE);

  logic            clk;
  logic [1:0]      r_rst_sync;
  logic            w_rst_core_n;
  logic            w_pci_alive;
  logic            w_qsfp_alive;
  logic            w_pcie_link_up;
  logic            w_qsfp_link_up;
  logic            unused_pins;

  assign clk          = fpga_sysclk_p;
  assign unused_pins  = ^{fpga_sysclk_n, pins.pci_clk_n, pins.qsfp_refclk_n,
                          pins.pcie_rxn, pins.qsfp0_rxn};

  always_ff @(posedge clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_core_n = r_rst_sync[1];

  clk_alive_mon #(
    .MON_WINDOW    (MON_WINDOW),
    .MON_MIN_EDGES (MON_MIN_EDGES)
  ) u_pci_mon (
    .clk     (clk),
    .rst_n   (sys_reset_n),
    .ref_clk (pins.pci_clk_p),
    .alive   (w_pci_alive)
  );

  clk_alive_mon #(
    .MON_WINDOW    (MON_WINDOW),
    .MON_MIN_EDGES (MON_MIN_EDGES)
  ) u_qsfp_mon (
    .clk     (clk),
    .rst_n   (sys_reset_n),
    .ref_clk (pins.qsfp_refclk_p),
    .alive   (w_qsfp_alive)
  );

  lane_link #(
    .LANES   (PCIE_LANES),
    .T_TRAIN (c_t_train)
  ) u_pcie_link (
    .clk        (clk),
    .rst_n      (sys_reset_n),
    .rst_core_n (w_rst_core_n),
    .alive      (w_pci_alive),
    .rxp        (pins.pcie_rxp),
    .txp        (pins.pcie_txp),
    .txn        (pins.pcie_txn),
    .link_up    (w_pcie_link_up)
  );

  lane_link #(
    .LANES   (QSFP_LANES),
    .T_TRAIN (c_t_train)
  ) u_qsfp_link (
    .clk        (clk),
    .rst_n      (sys_reset_n),
    .rst_core_n (w_rst_core_n),
    .alive      (w_qsfp_alive),
    .rxp        (pins.qsfp0_rxp),
    .txp        (pins.qsfp0_txp),
    .txn        (pins.qsfp0_txn),
    .link_up    (w_qsfp_link_up)
  );

  logic unused_status;
  assign unused_status = w_pcie_link_up ^ w_qsfp_link_up ^ (c_unused_cfg == 0);

endmodule

`default_nettype wire

// File: tb/tb_reference_switch_lite_sim_top.sv
// ============================================================================
// tb_reference_switch_lite_sim_top : scoreboard bench for fast and slow-training shells
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reference_switch_lite_sim_top;

  logic core_clk = 1'b0;
  logic core_clk_n;
  logic pci_clk  = 1'b0;
  logic qsfp_clk = 1'b0;
  logic qsfp_en  = 1'b1;
  logic sys_reset_n = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rel_cyc  = 0;
  bit rel_armed = 1'b0;
  int fast_up_cyc = 0;
  bit slow_seen = 1'b0;
  int slow_up_cyc = 0;

  reference_switch_lite_sim_top_if #(.PCIE_LANES(16), .QSFP_LANES(4)) f_if ();
  reference_switch_lite_sim_top_if #(.PCIE_LANES(16), .QSFP_LANES(4)) s_if ();

  assign core_clk_n      = ~core_clk;
  assign f_if.pci_clk_p  = pci_clk;
  assign f_if.pci_clk_n  = ~pci_clk;
  assign f_if.qsfp_refclk_p = qsfp_clk;
  assign f_if.qsfp_refclk_n = ~qsfp_clk;
  assign f_if.pcie_rxn   = ~f_if.pcie_rxp;
  assign f_if.qsfp0_rxn  = ~f_if.qsfp0_rxp;
  assign s_if.pci_clk_p  = pci_clk;
  assign s_if.pci_clk_n  = ~pci_clk;
  assign s_if.qsfp_refclk_p = qsfp_clk;
  assign s_if.qsfp_refclk_n = ~qsfp_clk;
  assign s_if.pcie_rxn   = ~s_if.pcie_rxp;
  assign s_if.qsfp0_rxn  = ~s_if.qsfp0_rxp;

  reference_switch_lite_sim_top #(.PL_SIM_FAST_LINK_TRAINING("TRUE")) dut_fast (
    .fpga_sysclk_p (core_clk),
    .fpga_sysclk_n (core_clk_n),
    .sys_reset_n   (sys_reset_n),
    .pins          (f_if)
  );

  reference_switch_lite_sim_top #(.PL_SIM_FAST_LINK_TRAINING("FALSE")) dut_slow (
    .fpga_sysclk_p (core_clk),
    .fpga_sysclk_n (core_clk_n),
    .sys_reset_n   (sys_reset_n),
    .pins          (s_if)
  );

  always #1.4705 core_clk = ~core_clk;
  always #2.0    pci_clk  = ~pci_clk;
  always #3.2    qsfp_clk = qsfp_en ? ~qsfp_clk : 1'b0;

  always @(posedge core_clk) cyc <= cyc + 1;

  // Slow-training shell link-up time, measured as the first cycle its loopback shows rx.
  always @(negedge core_clk) begin
    if (rel_armed && !slow_seen && (s_if.pcie_txp === 16'hA5C3)) begin
      slow_seen   = 1'b1;
      slow_up_cyc = cyc - rel_cyc;
    end
  end

  task automatic test_reset();
    logic [39:0] obs;
    sys_reset_n = 1'b0;
    repeat (200) begin
      @(negedge core_clk);
      obs = {f_if.pcie_txp, f_if.pcie_txn, f_if.qsfp0_txp, f_if.qsfp0_txn};
      n_checks++;
      if (obs !== {16'h0000, 16'hFFFF, 4'h0, 4'hF})
        $display("FAIL reset_idle: got %h required %h", obs, {16'h0000, 16'hFFFF, 4'h0, 4'hF});
      else n_pass++;
    end
  endtask

  task automatic test_pcie_link_up();
    bit up = 1'b0;
    @(negedge core_clk);
    sys_reset_n = 1'b1;
    rel_cyc     = cyc;
    rel_armed   = 1'b1;
    for (int k = 0; k < 600 && !up; k++) begin
      @(negedge core_clk);
      if (f_if.pcie_txp === 16'hA5C3) up = 1'b1;
    end
    fast_up_cyc = cyc - rel_cyc;
    n_checks++;
    if (!up || fast_up_cyc > 2*256 + 3 + 17)
      $display("FAIL pcie_link_up: up=%0b after %0d cycles, required up within %0d", up, fast_up_cyc, 2*256+3+17);
    else n_pass++;
    n_checks++;
    if (f_if.pcie_txn !== 16'h5A3C)
      $display("FAIL pcie_txn_up: got %h required %h", f_if.pcie_txn, 16'h5A3C);
    else n_pass++;
  endtask

  task automatic test_pcie_loopback();
    logic [15:0] sb[$];
    logic [15:0] v;
    logic [15:0] exp;
    for (int i = 0; i < 44; i++) begin
      @(negedge core_clk);
      if (sb.size() == 2) begin
        exp = sb.pop_front();
        n_checks++;
        if (f_if.pcie_txp !== exp)
          $display("FAIL pcie_loop_txp: got %h required %h", f_if.pcie_txp, exp);
        else n_pass++;
        n_checks++;
        if (f_if.pcie_txn !== ~exp)
          $display("FAIL pcie_loop_txn: got %h required %h", f_if.pcie_txn, ~exp);
        else n_pass++;
      end
      v = (i < 40) ? 16'($urandom) : 16'hA5C3;
      f_if.pcie_rxp = v;
      sb.push_back(v);
    end
  endtask

  task automatic test_qsfp_loopback();
    logic [3:0] sb[$];
    logic [3:0] v;
    logic [3:0] exp;
    bit up = 1'b0;
    for (int k = 0; k < 600 && !up; k++) begin
      @(negedge core_clk);
      if (f_if.qsfp0_txp === 4'h5) up = 1'b1;
    end
    n_checks++;
    if (!up) $display("FAIL qsfp_link_up: txp=%h required %h", f_if.qsfp0_txp, 4'h5);
    else n_pass++;
    for (int i = 0; i < 44; i++) begin
      @(negedge core_clk);
      if (sb.size() == 2) begin
        exp = sb.pop_front();
        n_checks++;
        if (f_if.qsfp0_txp !== exp)
          $display("FAIL qsfp_loop_txp: got %h required %h", f_if.qsfp0_txp, exp);
        else n_pass++;
        n_checks++;
        if (f_if.qsfp0_txn !== ~exp)
          $display("FAIL qsfp_loop_txn: got %h required %h", f_if.qsfp0_txn, ~exp);
        else n_pass++;
      end
      v = (i % 2 == 0) ? 4'h5 : 4'hA;
      f_if.qsfp0_rxp = v;
      sb.push_back(v);
    end
  endtask

  task automatic test_slow_training();
    for (int k = 0; k < 1500 && !slow_seen; k++) @(negedge core_clk);
    n_checks++;
    if (!slow_seen || slow_up_cyc != fast_up_cyc + (1024 - 16))
      $display("FAIL slow_training: seen=%0b up at %0d, required %0d (fast %0d + 1008)",
               slow_seen, slow_up_cyc, fast_up_cyc + 1008, fast_up_cyc);
    else n_pass++;
  endtask

  task automatic test_clock_stop();
    bit idle = 1'b0;
    int k;
    @(negedge core_clk);
    qsfp_en = 1'b0;
    for (k = 0; k < 2*256 + 2 && !idle; k++) begin
      @(negedge core_clk);
      if (f_if.qsfp0_txp === 4'h0 && f_if.qsfp0_txn === 4'hF) idle = 1'b1;
      else f_if.qsfp0_rxp = ~f_if.qsfp0_rxp;
    end
    n_checks++;
    if (!idle)
      $display("FAIL qsfp_clock_stop: txp=%h txn=%h after %0d cycles, required 0/f", f_if.qsfp0_txp, f_if.qsfp0_txn, k);
    else n_pass++;
    n_checks++;
    if (f_if.pcie_txp !== 16'hA5C3 || f_if.pcie_txn !== 16'h5A3C)
      $display("FAIL pcie_stays_up: txp=%h txn=%h required a5c3/5a3c", f_if.pcie_txp, f_if.pcie_txn);
    else n_pass++;
  endtask

  task automatic test_reset_mid_traffic();
    bit up = 1'b0;
    qsfp_en = 1'b1;
    f_if.qsfp0_rxp = 4'h5;
    repeat (4) @(negedge core_clk);
    n_checks++;
    if (f_if.pcie_txp !== 16'hA5C3)
      $display("FAIL pcie_up_before_reset: got %h required %h", f_if.pcie_txp, 16'hA5C3);
    else n_pass++;
    sys_reset_n = 1'b0;
    #0.3;
    n_checks++;
    if ({f_if.pcie_txp, f_if.pcie_txn} !== {16'h0000, 16'hFFFF})
      $display("FAIL reset_async_idle: got %h required %h", {f_if.pcie_txp, f_if.pcie_txn}, {16'h0000, 16'hFFFF});
    else n_pass++;
    @(negedge core_clk);
    n_checks++;
    if ({f_if.pcie_txp, f_if.qsfp0_txp} !== 20'h0)
      $display("FAIL reset_hold_idle: got %h required %h", {f_if.pcie_txp, f_if.qsfp0_txp}, 20'h0);
    else n_pass++;
    sys_reset_n = 1'b1;
    for (int k = 0; k < 600 && !up; k++) begin
      @(negedge core_clk);
      if (f_if.pcie_txp === 16'hA5C3 && f_if.qsfp0_txp === 4'h5) up = 1'b1;
    end
    n_checks++;
    if (!up)
      $display("FAIL relink_after_reset: pcie=%h qsfp=%h required a5c3/5", f_if.pcie_txp, f_if.qsfp0_txp);
    else n_pass++;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    f_if.pcie_rxp  = 16'hA5C3;
    f_if.qsfp0_rxp = 4'h5;
    s_if.pcie_rxp  = 16'hA5C3;
    s_if.qsfp0_rxp = 4'h5;
    test_reset();
    test_pcie_link_up();
    test_pcie_loopback();
    test_qsfp_loopback();
    test_slow_training();
    test_clock_stop();
    test_reset_mid_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reference_switch_lite_sim_top.md
# reference_switch_lite_sim_top

Simulation-level top of the reference switch lite project. Provides the pin-level shell that the project bench drives: PCIe and QSFP0 serial lane pins, three differential clock inputs, and a system reset. Serial lanes are modelled behaviourally as registered loopback paths, gated by link-up. Link-up requires reset release and a detected reference clock. Everything runs in the core clock domain.

## Interface
- PL_SIM_FAST_LINK_TRAINING, "TRUE": selects link-training delay; "TRUE" = 16 cycles, otherwise 1024 cycles.
- C_DATA_WIDTH, 512: recorded only; no functional effect.
- KEEP_WIDTH, C_DATA_WIDTH/32: recorded only.
- USER_CLK2_FREQ, 4: recorded only.
- REF_CLK_FREQ, 0: recorded only.
- AXISTEN_IF_* group: recorded only. Defaults: RQ/CC/CQ/RC_ALIGNMENT_MODE "FALSE"; ENABLE_CLIENT_TAG, RQ/CC_PARITY_CHECK, MC_RX_STRADDLE, ENABLE_RX_MSG_INTFC 0; ENABLE_MSG_ROUTE 18'h2FFFF.
- PCIE_LANES, 16: PCIe lane count.
- QSFP_LANES, 4: QSFP0 lane count.
- MON_WINDOW, 256: clock-monitor window length in core cycles.
- MON_MIN_EDGES, 16: minimum detected edges per window for "alive".
- fpga_sysclk_p / fpga_sysclk_n, in, 1 each: differential core clock. Only one clock is used: fpga_sysclk_p rising edges; _n is ignored.
- sys_reset_n, in, 1: reset, asynchronous and active-low.
- pci_clk_p / pci_clk_n, in, 1 each: PCIe reference clock, sampled as data; _n ignored.
- qsfp_refclk_p / qsfp_refclk_n, in, 1 each: QSFP reference clock, sampled as data; _n ignored.
- pcie_rxp / pcie_rxn, in, PCIE_LANES each: PCIe receive lanes.
- pcie_txp / pcie_txn, out, PCIE_LANES each: PCIe transmit lanes.
- qsfp0_rxp / qsfp0_rxn, in, QSFP_LANES each: QSFP0 receive lanes.
- qsfp0_txp / qsfp0_txn, out, QSFP_LANES each: QSFP0 transmit lanes.

## Operation
- Reset synchronizer
  - Two flops, asynchronously cleared by sys_reset_n low.
  - Release is synchronous after 2 core edges, producing rst_core_n.
  - All other state clears asynchronously on sys_reset_n low.
- Clock monitors (one each for pci_clk_p and qsfp_refclk_p)
  - 3-flop synchronizer, then rising-edge detect on the last two stages.
  - Window counter runs 0..MON_WINDOW-1; edge counter saturates at 255.
  - At window end, the edge counter is cleared and alive <= (edge count >= MON_MIN_EDGES), where the count includes any edge detected in the window's final cycle.
  - alive resets to 0.
- Link FSM, one per interface
  - PCIe uses pci alive; QSFP0 uses qsfp alive.
  - States: DOWN -> TRAIN when alive=1 and rst_core_n=1.
  - TRAIN counts to T_TRAIN (16 or 1024), then -> UP.
  - Any state -> DOWN in the cycle after alive drops.
  - link_up = (state==UP).
- Lane datapath
  - Two-stage register pipeline per interface: stage1 <= rxp, stage2 <= stage1.
  - While link_up: txp = stage2, txn = ~stage2.
  - While not link_up: idle, txp = 0, txn = all ones.
  - Pipeline registers update regardless of link_up.
- Reset mid-operation: all outputs go to idle immediately (asynchronously), and the FSMs restart from DOWN.

## Timing
- Reset values: pcie_txp=0, pcie_txn=all ones, qsfp0_txp=0, qsfp0_txn=all ones.
- Rx to tx latency while UP: 2 core cycles.
- First alive evaluation: at most 2*MON_WINDOW+3 cycles after release, given a running reference clock.
- Link-up latency after alive: 1 (DOWN->TRAIN) + T_TRAIN cycles.
- Same-cycle alive drop and TRAIN completion: DOWN wins.

## Structure
- Package sim_top_pkg holds:
  - lane-count defaults;
  - MON_WINDOW / MON_MIN_EDGES;
  - T_TRAIN_FAST=16 / T_TRAIN_SLOW=1024;
  - link state enum {DOWN, TRAIN, UP}.
- Sub-module clk_alive_mon, instantiated twice.
- Link FSM plus pipeline coded per interface, or as a small lane_link sub-module.

## Test plan
1. **Reset hold.** sys_reset_n=0 for 200 core cycles with all clocks running -> all txp=0 and txn=all ones throughout.
2. **PCIe link-up and loopback.** Core 2.941 ns, pci 4.0 ns, qsfp 6.4 ns; release reset; drive pcie_rxp=16'hA5C3 -> pcie link UP within 2*256+3+17 cycles. Once UP, pcie_txp=16'hA5C3 and pcie_txn=16'h5A3C two cycles after any rx change.
3. **QSFP loopback.** Same setup; qsfp0_rxp toggles 4'h5 / 4'hA each cycle -> qsfp0_txp reproduces the sequence delayed 2 cycles.
4. **Clock stop.** Stop qsfp_refclk -> qsfp0 returns to idle (txp=0, txn=4'hF) within 2*256+2 cycles; PCIe stays UP.
5. **Slow training.** PL_SIM_FAST_LINK_TRAINING="FALSE" -> UP occurs exactly 1025 cycles after alive rises.
6. **Reset mid-traffic.** Pulse sys_reset_n low for 1 cycle while UP -> outputs idle at once; link re-trains and recovers.
